// File: rtl/term_char_if.sv
// Byte-stream input and character-buffer port A signals of the terminal writer.
interface term_char_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] buf_addr;
  logic [7:0]  buf_din;
  logic        buf_we;
  logic        buf_ce;
  logic [4:0]  top_row;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, buf_addr, buf_din, buf_we, buf_ce,
    input  top_row, cursor_col, cursor_row, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, buf_addr, buf_din, buf_we, buf_ce,
    output top_row, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/term_char_writer.sv
// Terminal character writer: byte stream -> 4096x8 buffer writes, cursor and scroll offset.
// Optional macro TERM_TAB_EN enables HT (0x09) tab stops every 8 columns.
module term_char_writer #(
  parameter int unsigned COLS     = 80,
  parameter int unsigned ROWS     = 30,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic      clk,
  input  logic      resetn,
  term_char_if.slave bus
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, CLRLINE} state_t;

  state_t      state;
  logic [4:0]  cnt_row;
  logic [6:0]  cnt_col;
  logic [4:0]  clr_row;
  logic        fill_last;
  logic [11:0] addr_q;
  logic [7:0]  din_q;
  logic        we_q;
  logic [4:0]  top_q;
  logic [4:0]  row_q;
  logic [6:0]  col_q;

  logic [5:0]  phys_sum;
  logic [4:0]  phys_row;
  logic        accept;
  logic        printable;
  logic        do_nl;
`ifdef TERM_TAB_EN
  logic [7:0]  tab_next;
`endif

  // Logical cursor row to physical buffer row through the circular top offset
  always_comb begin
    phys_sum  = 6'(top_q) + 6'(row_q);
    phys_row  = (phys_sum >= 6'(ROWS)) ? 5'(phys_sum - 6'(ROWS)) : phys_sum[4:0];
    accept    = bus.in_valid && (state == IDLE);
    printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
    do_nl     = accept && ((printable && (col_q == LAST_COL)) || (bus.in_data == 8'h0A));
  end

`ifdef TERM_TAB_EN
  assign tab_next = 8'({1'b0, col_q[6:3], 3'b000}) + 8'd8;
`endif

  // fill_last holds the FSM one extra cycle so the final fill write is visible while still busy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= CLEAR;
      cnt_row   <= '0;
      cnt_col   <= '0;
      clr_row   <= '0;
      fill_last <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
      top_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      we_q <= 1'b0;
      case (state)
        CLEAR: begin
          if (fill_last) begin
            state     <= IDLE;
            fill_last <= 1'b0;
            top_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
          end else begin
            we_q   <= 1'b1;
            addr_q <= {cnt_row, cnt_col};
            din_q  <= CLR_CHAR;
            if (cnt_col == LAST_COL) begin
              cnt_col <= '0;
              if (cnt_row == LAST_ROW) fill_last <= 1'b1;
              else                     cnt_row   <= cnt_row + 5'd1;
            end else begin
              cnt_col <= cnt_col + 7'd1;
            end
          end
        end
        CLRLINE: begin
          if (fill_last) begin
            state     <= IDLE;
            fill_last <= 1'b0;
          end else begin
            we_q   <= 1'b1;
            addr_q <= {clr_row, cnt_col};
            din_q  <= CLR_CHAR;
            if (cnt_col == LAST_COL) fill_last <= 1'b1;
            else                     cnt_col   <= cnt_col + 7'd1;
          end
        end
        IDLE: begin
          if (accept) begin
            if (printable) begin
              we_q   <= 1'b1;
              addr_q <= {phys_row, col_q};
              din_q  <= bus.in_data;
              col_q  <= (col_q == LAST_COL) ? 7'd0 : col_q + 7'd1;
            end else begin
              case (bus.in_data)
                8'h0D: col_q <= '0;
                8'h08: if (col_q != 7'd0) col_q <= col_q - 7'd1;
                8'h0C: begin
                  state   <= CLEAR;
                  cnt_row <= '0;
                  cnt_col <= '0;
                end
`ifdef TERM_TAB_EN
                8'h09: col_q <= (tab_next > 8'(LAST_COL)) ? LAST_COL : tab_next[6:0];
`endif
                default: ;
              endcase
            end
            // Scroll on newline from the bottom row: old top row becomes the cleared bottom line
            if (do_nl) begin
              if (row_q != LAST_ROW) begin
                row_q <= row_q + 5'd1;
              end else begin
                top_q   <= (top_q == LAST_ROW) ? 5'd0 : top_q + 5'd1;
                clr_row <= top_q;
                cnt_col <= '0;
                state   <= CLRLINE;
              end
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.buf_addr   = addr_q;
  assign bus.buf_din    = din_q;
  assign bus.buf_we     = we_q;
  assign bus.buf_ce     = we_q;
  assign bus.top_row    = top_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;

endmodule

// File: tb/tb_term_char_writer.sv
// Directed bench for term_char_writer with COLS=80, ROWS=30.
module tb_term_char_writer;

  localparam int COLS = 80;
  localparam int ROWS = 30;
`ifdef TERM_TAB_EN
  localparam int TC  = 8;
  localparam int TC3 = 8;
  localparam int TC78 = 79;
`else
  localparam int TC  = 1;
  localparam int TC3 = 3;
  localparam int TC78 = 78;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  term_char_if bus ();

  term_char_writer #(.COLS(COLS), .ROWS(ROWS), .CLR_CHAR(8'h20)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       we;
    int         addr;
    int         din;
    int         col;
    int         row;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_we"},    int'(bus.buf_we), 0);
    chk({nm, "_ce"},    int'(bus.buf_ce), 0);
    chk({nm, "_addr"},  int'(bus.buf_addr), 0);
    chk({nm, "_din"},   int'(bus.buf_din), 0);
    chk({nm, "_top"},   int'(bus.top_row), 0);
    chk({nm, "_col"},   int'(bus.cursor_col), 0);
    chk({nm, "_row"},   int'(bus.cursor_row), 0);
    chk({nm, "_ready"}, int'(bus.in_ready), 0);
    chk({nm, "_busy"},  int'(bus.busy), 1);
  endtask

  // Full-screen fill: 2400 row-major writes of 0x20, then ready with cursor/top at zero
  task automatic do_clear(input string nm);
    int n = 0;
    int errs = 0;
    int first_bad = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.in_ready) break;
      if (bus.buf_we) begin
        int exp_addr = (n / COLS) * 128 + (n % COLS);
        if (int'(bus.buf_addr) != exp_addr || bus.buf_din != 8'h20 || !bus.buf_ce) begin
          errs++;
          if (first_bad < 0) first_bad = n;
        end
        n++;
      end
    end
    chk({nm, "_writes"}, n, ROWS * COLS);
    chk({nm, "_bad_cells_first"}, errs == 0 ? 0 : first_bad, 0);
    chk({nm, "_ready"}, int'(bus.in_ready), 1);
    chk({nm, "_we_off"}, int'(bus.buf_we), 0);
    chk({nm, "_top"}, int'(bus.top_row), 0);
    chk({nm, "_col"}, int'(bus.cursor_col), 0);
    chk({nm, "_row"}, int'(bus.cursor_row), 0);
  endtask

  // One-line fill at physical row base; optionally holds a byte on the input meanwhile
  task automatic do_line(input string nm, input int base, input bit hold);
    int n = 0;
    int errs = 0;
    if (hold) begin
      bus.in_data  = 8'h51;
      bus.in_valid = 1'b1;
    end
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.in_ready) break;
      if (bus.buf_we) begin
        if (int'(bus.buf_addr) != base + n || bus.buf_din != 8'h20) errs++;
        n++;
      end
    end
    bus.in_valid = 1'b0;
    chk({nm, "_writes"}, n, COLS);
    chk({nm, "_bad_cells"}, errs, 0);
    chk({nm, "_ready"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    vec_t vecs[13];
    int   wcnt;

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    vecs[0]  = '{8'h41, 1'b1, 12'h000, 8'h41, 1, 0};
    vecs[1]  = '{8'h42, 1'b1, 12'h001, 8'h42, 2, 0};
    vecs[2]  = '{8'h0D, 1'b0, 0, 0, 0, 0};
    vecs[3]  = '{8'h0A, 1'b0, 0, 0, 0, 1};
    vecs[4]  = '{8'h43, 1'b1, 12'h080, 8'h43, 1, 1};
    vecs[5]  = '{8'h08, 1'b0, 0, 0, 0, 1};
    vecs[6]  = '{8'h08, 1'b0, 0, 0, 0, 1};
    vecs[7]  = '{8'h01, 1'b0, 0, 0, 0, 1};
    vecs[8]  = '{8'h7F, 1'b0, 0, 0, 0, 1};
    vecs[9]  = '{8'h7E, 1'b1, 12'h080, 8'h7E, 1, 1};
    vecs[10] = '{8'h09, 1'b0, 0, 0, TC, 1};
    vecs[11] = '{8'h20, 1'b1, 12'h080 + TC, 8'h20, TC + 1, 1};
    vecs[12] = '{8'h0D, 1'b0, 0, 0, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    resetn = 1'b1;
    do_clear("init");

    // Back-to-back directed bytes
    for (int i = 0; i < 13; i++) begin
      send_byte(vecs[i].data);
      chk($sformatf("v%0d_we", i), int'(bus.buf_we), int'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_addr", i), int'(bus.buf_addr), vecs[i].addr);
        chk($sformatf("v%0d_din", i), int'(bus.buf_din), vecs[i].din);
      end
      chk($sformatf("v%0d_col", i), int'(bus.cursor_col), vecs[i].col);
      chk($sformatf("v%0d_row", i), int'(bus.cursor_row), vecs[i].row);
    end

    // Eager wrap at end of row 2
    send_byte(8'h0A);
    for (int i = 0; i < COLS; i++) send_byte(8'h42);
    chk("wrap_we", int'(bus.buf_we), 1);
    chk("wrap_addr", int'(bus.buf_addr), 12'h14F);
    chk("wrap_col", int'(bus.cursor_col), 0);
    chk("wrap_row", int'(bus.cursor_row), 3);
    @(posedge clk);
    #1;
    chk("wrap_no_extra", int'(bus.buf_we), 0);
    send_byte(8'h08);
    chk("bs_col0", int'(bus.cursor_col), 0);
    chk("bs_no_we", int'(bus.buf_we), 0);
    send_byte(8'h0D);
    chk("cr_col0", int'(bus.cursor_col), 0);

    // Reach the bottom row, then scroll
    for (int i = 0; i < 26; i++) send_byte(8'h0A);
    chk("bottom_row", int'(bus.cursor_row), 29);
    chk("bottom_top", int'(bus.top_row), 0);
    for (int i = 0; i < 5; i++) send_byte(8'h78);
    send_byte(8'h0A);
    chk("scroll_top", int'(bus.top_row), 1);
    chk("scroll_row", int'(bus.cursor_row), 29);
    chk("scroll_ready", int'(bus.in_ready), 0);
    chk("scroll_busy", int'(bus.busy), 1);
    do_line("line0", 12'h000, 1'b1);
    send_byte(8'h5A);
    chk("post_scroll_addr", int'(bus.buf_addr), 12'h005);
    chk("post_scroll_din", int'(bus.buf_din), 8'h5A);
    chk("post_scroll_col", int'(bus.cursor_col), 6);

    // Printable at the last cell: char write then line clear of old top row 1
    for (int i = 0; i < 73; i++) send_byte(8'h61);
    chk("lastcell_col", int'(bus.cursor_col), 79);
    send_byte(8'h62);
    chk("lastcell_we", int'(bus.buf_we), 1);
    chk("lastcell_addr", int'(bus.buf_addr), 12'h04F);
    chk("lastcell_din", int'(bus.buf_din), 8'h62);
    chk("lastcell_col0", int'(bus.cursor_col), 0);
    chk("lastcell_top", int'(bus.top_row), 2);
    chk("lastcell_ready", int'(bus.in_ready), 0);
    do_line("line1", 12'h080, 1'b0);

    // Reset during the 40th write of a line clear of physical row 2
    send_byte(8'h0A);
    chk("scroll2_top", int'(bus.top_row), 3);
    wcnt = 0;
    for (int cyc = 0; cyc < 200 && wcnt < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.buf_we) wcnt++;
    end
    chk("mid_write40_addr", int'(bus.buf_addr), 12'h100 + 39);
    resetn = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    resetn = 1'b1;
    do_clear("reclear");

    // Form feed mid-screen
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h0A);
    chk("ff_pre_row", int'(bus.cursor_row), 1);
    chk("ff_pre_col", int'(bus.cursor_col), 2);
    send_byte(8'h0C);
    chk("ff_busy", int'(bus.busy), 1);
    chk("ff_no_we", int'(bus.buf_we), 0);
    do_clear("ffclear");

    // Horizontal tab stops
    for (int i = 0; i < 3; i++) send_byte(8'h63);
    send_byte(8'h09);
    chk("tab3_col", int'(bus.cursor_col), TC3);
    chk("tab3_no_we", int'(bus.buf_we), 0);
    send_byte(8'h0D);
    for (int i = 0; i < 78; i++) send_byte(8'h64);
    chk("pre_tab78_col", int'(bus.cursor_col), 78);
    send_byte(8'h09);
    chk("tab78_col", int'(bus.cursor_col), TC78);
    chk("tab78_row", int'(bus.cursor_row), 0);
    chk("tab78_no_we", int'(bus.buf_we), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
